// File: rtl/csync_decoder_pkg.sv
// ---------------------------------------------------------------------------
// csync_dec_pkg
// Shared types and default constants for the composite-sync decoder.
//   dec_state_e   : decoder FSM states (SEARCH, VBLANK, COUNT)
//   pulse_class_e : classification of one completed csync-high pulse
//   DEF_*         : default parameter values used by csync_decoder
// ---------------------------------------------------------------------------
package csync_dec_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VBLANK = 2'd1,
    COUNT  = 2'd2
  } dec_state_e;

  typedef enum logic [2:0] {
    P_NONE   = 3'd0,
    P_GLITCH = 3'd1,
    P_LINE   = 3'd2,
    P_BROAD  = 3'd3,
    P_BAD    = 3'd4
  } pulse_class_e;

  localparam int DEF_CNT_W       = 10;
  localparam int DEF_LINE_W      = 10;
  localparam int DEF_HSYNC_MIN   = 8;
  localparam int DEF_HSYNC_MAX   = 40;
  localparam int DEF_VSYNC_MIN   = 100;
  localparam int DEF_TIMEOUT     = 1023;
  localparam int DEF_LOCK_FRAMES = 2;

endpackage

// File: rtl/csync_decoder_pulse_meas.sv
// ---------------------------------------------------------------------------
// csync_pulse_meas
// Synchronizes csync/cblank, detects csync edges, measures the high width of
// each csync pulse and classifies it when the pulse ends.
// Ports:
//   blif_clk_net   in   clock
//   blif_reset_net in   asynchronous active-high reset
//   csync_in       in   raw composite sync (active-high)
//   cblank_in      in   raw composite blank (active-high)
//   pulse_class    out  class of the pulse that just ended (P_NONE otherwise),
//                       valid for exactly the synchronized-fall cycle
//   rise_seen      out  1-cycle strobe on a qualified synchronized csync rise
//   blank_sync     out  cblank after the 2-flop synchronizer
// ---------------------------------------------------------------------------
module csync_pulse_meas
  import csync_dec_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int HSYNC_MIN = DEF_HSYNC_MIN,
  parameter int HSYNC_MAX = DEF_HSYNC_MAX,
  parameter int VSYNC_MIN = DEF_VSYNC_MIN
) (
  input  logic         blif_clk_net,
  input  logic         blif_reset_net,
  input  logic         csync_in,
  input  logic         cblank_in,
  output pulse_class_e pulse_class,
  output logic         rise_seen,
  output logic         blank_sync
);

  localparam logic [CNT_W-1:0] HMIN_C  = CNT_W'(HSYNC_MIN);
  localparam logic [CNT_W-1:0] HMAX_C  = CNT_W'(HSYNC_MAX);
  localparam logic [CNT_W-1:0] VMIN_C  = CNT_W'(VSYNC_MIN);
  localparam logic [CNT_W-1:0] WIDTH_SAT = '1;

  logic             csync_s1_q, csync_s1_d;
  logic             csync_s2_q, csync_s2_d;
  logic             csync_s3_q, csync_s3_d;
  logic             blank_s1_q, blank_s1_d;
  logic             blank_s2_q, blank_s2_d;
  logic [1:0]       settle_q, settle_d;
  logic             in_pulse_q, in_pulse_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             rise;
  logic             fall;

  // The sync chain holds reset values for three clocks after reset, so an edge
  // seen before settle_q saturates is an artefact of reset, not a real rise.
  // in_pulse_q marks a pulse whose rise was genuinely observed; a pulse that
  // was already high across reset is never classified.
  // The rise cycle itself counts as the first high clock, so the width held at
  // the fall equals the number of clocks csync was sampled high.
  always_comb begin
    csync_s1_d = csync_in;
    csync_s2_d = csync_s1_q;
    csync_s3_d = csync_s2_q;
    blank_s1_d = cblank_in;
    blank_s2_d = blank_s1_q;

    settle_d = settle_q;
    if (settle_q != 2'd3) settle_d = settle_q + 2'd1;

    rise = csync_s2_q & ~csync_s3_q & (settle_q == 2'd3);
    fall = ~csync_s2_q & csync_s3_q & in_pulse_q;

    in_pulse_d = in_pulse_q;
    width_d    = width_q;
    if (rise) begin
      in_pulse_d = 1'b1;
      width_d    = CNT_W'(1);
    end else if (csync_s2_q && in_pulse_q && (width_q != WIDTH_SAT)) begin
      width_d = width_q + CNT_W'(1);
    end
    if (fall) in_pulse_d = 1'b0;

    pulse_class = P_NONE;
    if (fall) begin
      if (width_q < HMIN_C)       pulse_class = P_GLITCH;
      else if (width_q <= HMAX_C) pulse_class = P_LINE;
      else if (width_q >= VMIN_C) pulse_class = P_BROAD;
      else                        pulse_class = P_BAD;
    end

    rise_seen  = rise;
    blank_sync = blank_s2_q;
  end

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      csync_s1_q <= 1'b0;
      csync_s2_q <= 1'b0;
      csync_s3_q <= 1'b0;
      blank_s1_q <= 1'b0;
      blank_s2_q <= 1'b0;
      settle_q   <= 2'd0;
      in_pulse_q <= 1'b0;
      width_q    <= '0;
    end else begin
      csync_s1_q <= csync_s1_d;
      csync_s2_q <= csync_s2_d;
      csync_s3_q <= csync_s3_d;
      blank_s1_q <= blank_s1_d;
      blank_s2_q <= blank_s2_d;
      settle_q   <= settle_d;
      in_pulse_q <= in_pulse_d;
      width_q    <= width_d;
    end
  end

endmodule

// File: rtl/csync_decoder.sv
// ---------------------------------------------------------------------------
// csync_decoder
// Decodes composite sync/blank back into line and frame timing, and reports
// lock once consecutive frames have the same number of lines.
// Optional feature macro: CSYNC_DECODER_STATS_EN (saturating error counter).
// Ports:
//   blif_clk_net   in   clock
//   blif_reset_net in   asynchronous active-high reset
//   csync_in       in   composite sync (active-high)
//   cblank_in      in   composite blank (active-high)
//   hs_pulse       out  1-cycle strobe: valid line sync ended
//   vs_start       out  1-cycle strobe: first broad pulse of a frame ended
//   line_cnt       out  lines since the last vertical interval
//   frame_lines    out  line count of the last completed frame
//   locked         out  frame timing stable
//   err_pulse      out  1-cycle strobe: bad pulse width or idle timeout
//   blank_o        out  synchronized cblank
//   err_cnt        out  saturating error count (0 when the macro is undefined)
// ---------------------------------------------------------------------------
module csync_decoder
  import csync_dec_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LINE_W      = DEF_LINE_W,
  parameter int HSYNC_MIN   = DEF_HSYNC_MIN,
  parameter int HSYNC_MAX   = DEF_HSYNC_MAX,
  parameter int VSYNC_MIN   = DEF_VSYNC_MIN,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              csync_in,
  input  logic              cblank_in,
  output logic              hs_pulse,
  output logic              vs_start,
  output logic [LINE_W-1:0] line_cnt,
  output logic [LINE_W-1:0] frame_lines,
  output logic              locked,
  output logic              err_pulse,
  output logic              blank_o,
  output logic [7:0]        err_cnt
);

  localparam int               GOOD_W     = $clog2(LOCK_FRAMES + 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [LINE_W-1:0] LINE_SAT  = '1;

  pulse_class_e pulse_class;
  logic         rise_seen;

  dec_state_e        state_q, state_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [LINE_W-1:0] frame_lines_q, frame_lines_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              locked_q, locked_d;
  logic              hs_pulse_q, hs_pulse_d;
  logic              vs_start_q, vs_start_d;
  logic              err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic              timeout_ev;
  logic              frame_match;
  logic [GOOD_W-1:0] good_inc;

  csync_pulse_meas #(
    .CNT_W     (CNT_W),
    .HSYNC_MIN (HSYNC_MIN),
    .HSYNC_MAX (HSYNC_MAX),
    .VSYNC_MIN (VSYNC_MIN)
  ) u_meas (
    .blif_clk_net   (blif_clk_net),
    .blif_reset_net (blif_reset_net),
    .csync_in       (csync_in),
    .cblank_in      (cblank_in),
    .pulse_class    (pulse_class),
    .rise_seen      (rise_seen),
    .blank_sync     (blank_o)
  );

  // The idle counter parks at TIMEOUT, so a long silence raises err_pulse only
  // once. Timeout and BAD share one branch ahead of the FSM, which is how a
  // timeout wins over a classification in the same cycle. Entering SEARCH
  // clears frame_lines, and a zero frame_lines never matches, so the first
  // frame after SEARCH cannot count towards lock.
  always_comb begin
    state_d       = state_q;
    line_cnt_d    = line_cnt_q;
    frame_lines_d = frame_lines_q;
    good_d        = good_q;
    locked_d      = locked_q;
    hs_pulse_d    = 1'b0;
    vs_start_d    = 1'b0;
    err_pulse_d   = 1'b0;

    idle_d = idle_q;
    if (rise_seen)                idle_d = '0;
    else if (idle_q != TIMEOUT_C) idle_d = idle_q + CNT_W'(1);
    timeout_ev = !rise_seen && (idle_q == TIMEOUT_M1);

    frame_match = (frame_lines_q != '0) && (line_cnt_q == frame_lines_q);
    good_inc    = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_W'(1);

    if (timeout_ev || (pulse_class == P_BAD)) begin
      err_pulse_d   = 1'b1;
      state_d       = SEARCH;
      locked_d      = 1'b0;
      good_d        = '0;
      line_cnt_d    = '0;
      frame_lines_d = '0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (pulse_class == P_BROAD) begin
            vs_start_d = 1'b1;
            line_cnt_d = '0;
            state_d    = VBLANK;
          end
        end
        VBLANK: begin
          if (pulse_class == P_LINE) begin
            hs_pulse_d = 1'b1;
            line_cnt_d = LINE_W'(1);
            state_d    = COUNT;
          end
        end
        COUNT: begin
          if (pulse_class == P_LINE) begin
            hs_pulse_d = 1'b1;
            if (line_cnt_q != LINE_SAT) line_cnt_d = line_cnt_q + LINE_W'(1);
          end else if (pulse_class == P_BROAD) begin
            vs_start_d    = 1'b1;
            frame_lines_d = line_cnt_q;
            line_cnt_d    = '0;
            state_d       = VBLANK;
            if (frame_match) begin
              good_d = good_inc;
              if (good_inc == GOOD_MAX) locked_d = 1'b1;
            end else begin
              good_d   = '0;
              locked_d = 1'b0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state_q       <= SEARCH;
      line_cnt_q    <= '0;
      frame_lines_q <= '0;
      good_q        <= '0;
      locked_q      <= 1'b0;
      hs_pulse_q    <= 1'b0;
      vs_start_q    <= 1'b0;
      err_pulse_q   <= 1'b0;
      idle_q        <= '0;
    end else begin
      state_q       <= state_d;
      line_cnt_q    <= line_cnt_d;
      frame_lines_q <= frame_lines_d;
      good_q        <= good_d;
      locked_q      <= locked_d;
      hs_pulse_q    <= hs_pulse_d;
      vs_start_q    <= vs_start_d;
      err_pulse_q   <= err_pulse_d;
      idle_q        <= idle_d;
    end
  end

  assign hs_pulse    = hs_pulse_q;
  assign vs_start    = vs_start_q;
  assign line_cnt    = line_cnt_q;
  assign frame_lines = frame_lines_q;
  assign locked      = locked_q;
  assign err_pulse   = err_pulse_q;

`ifdef CSYNC_DECODER_STATS_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts on the same edge that raises err_pulse; sticks at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_pulse_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) err_cnt_q <= 8'd0;
    else                err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule
